// File: rtl/timer_sched_pkg.sv
// Shared types and timer register map for the interval-timer scheduler.
// The timer is a 16-bit-register Avalon slave programmed over a write-only port.
package timer_sched_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_WR_STOP,
    S_WR_CLR0,
    S_WR_PL,
    S_WR_PH,
    S_GAP,
    S_WR_START,
    S_WAIT,
    S_WR_ABORT,
    S_WR_CLR1,
    S_WR_OFF,
    S_DONE
  } state_t;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;

  localparam logic [15:0] CTRL_STOP             = 16'h0008;
  localparam logic [15:0] CTRL_START_ONESHOT_IE = 16'h0005;
  localparam logic [15:0] CTRL_OFF              = 16'h0000;

endpackage

// File: rtl/timer_sched_ctrl_rr_arbiter.sv
// Round-robin arbiter: searches the request vector starting at ptr and
// returns the first requester found as one-hot grant plus index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               req_any
);

  always_comb begin
    logic [IDX_W-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    req_any   = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!req_any && req[cand]) begin
        req_any     = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/timer_sched_ctrl.sv
// Shares one interval timer among NUM_REQ requesters: grants one-shot delays
// round-robin, programs the timer, waits for irq or cancel, reports completion.
module timer_sched_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [32*NUM_REQ-1:0]  req_period,
  input  logic [NUM_REQ-1:0]     cancel,
  output logic [NUM_REQ-1:0]     done,
  output logic                   aborted,
  output logic                   busy,
  output logic [IDX_W-1:0]       owner,
  output logic [2:0]             tmr_address,
  output logic                   tmr_chipselect,
  output logic                   tmr_write_n,
  output logic [15:0]            tmr_writedata,
  input  logic                   tmr_irq
);
  import timer_sched_pkg::*;

  state_t             state, state_next;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_next, owner_next;
  logic               abort_q, abort_next;
  logic [31:0]        period_q, period_sel;
  logic               load_period;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               req_any;
  logic               wr_next;
  logic [2:0]         addr_next;
  logic [15:0]        data_next;
  logic [NUM_REQ-1:0] done_next;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req       (req),
    .ptr       (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .req_any   (req_any)
  );

  always_comb begin
    period_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) period_sel = req_period[32*i +: 32];
  end

  always_comb begin
    state_next  = state;
    rr_ptr_next = rr_ptr;
    owner_next  = owner;
    abort_next  = abort_q;
    load_period = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_any) begin
          owner_next  = grant_idx;
          rr_ptr_next = IDX_W'((int'(grant_idx) + 1) % NUM_REQ);
          load_period = 1'b1;
          abort_next  = 1'b0;
          state_next  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (period_q == 32'd0) begin
          abort_next = 1'b1;
          state_next = S_DONE;
        end else begin
          state_next = S_WR_STOP;
        end
      end
      S_WR_STOP:  state_next = S_WR_CLR0;
      S_WR_CLR0:  state_next = S_WR_PL;
      S_WR_PL:    state_next = S_WR_PH;
      S_WR_PH:    state_next = S_GAP;
      S_GAP:      state_next = S_WR_START;
      S_WR_START: state_next = S_WAIT;
      S_WAIT: begin
        // irq takes priority over a cancel arriving in the same cycle
        if (tmr_irq) begin
          abort_next = 1'b0;
          state_next = S_WR_CLR1;
        end else if (cancel[owner]) begin
          abort_next = 1'b1;
          state_next = S_WR_ABORT;
        end
      end
      S_WR_ABORT: state_next = S_WR_CLR1;
      S_WR_CLR1:  state_next = S_WR_OFF;
      S_WR_OFF:   state_next = S_DONE;
      S_DONE:     state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  // Master outputs are decoded from the next state so the bus is registered.
  always_comb begin
    wr_next   = 1'b0;
    addr_next = '0;
    data_next = '0;
    done_next = '0;
    case (state_next)
      S_WR_STOP, S_WR_ABORT: begin
        wr_next   = 1'b1;
        addr_next = ADDR_CONTROL;
        data_next = CTRL_STOP;
      end
      S_WR_CLR0, S_WR_CLR1: begin
        wr_next   = 1'b1;
        addr_next = ADDR_STATUS;
        data_next = 16'h0000;
      end
      S_WR_PL: begin
        wr_next   = 1'b1;
        addr_next = ADDR_PERIOD_L;
        data_next = period_q[15:0];
      end
      S_WR_PH: begin
        wr_next   = 1'b1;
        addr_next = ADDR_PERIOD_H;
        data_next = period_q[31:16];
      end
      S_WR_START: begin
        wr_next   = 1'b1;
        addr_next = ADDR_CONTROL;
        data_next = CTRL_START_ONESHOT_IE;
      end
      S_WR_OFF: begin
        wr_next   = 1'b1;
        addr_next = ADDR_CONTROL;
        data_next = CTRL_OFF;
      end
      S_DONE: done_next[owner_next] = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      rr_ptr         <= '0;
      owner          <= '0;
      abort_q        <= 1'b0;
      busy           <= 1'b0;
      done           <= '0;
      aborted        <= 1'b0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= '0;
      tmr_writedata  <= '0;
    end else begin
      state          <= state_next;
      rr_ptr         <= rr_ptr_next;
      owner          <= owner_next;
      abort_q        <= abort_next;
      busy           <= (state_next != S_IDLE);
      done           <= done_next;
      aborted        <= (state_next == S_DONE) && abort_next;
      tmr_chipselect <= wr_next;
      tmr_write_n    <= !wr_next;
      tmr_address    <= addr_next;
      tmr_writedata  <= data_next;
    end
  end

  // Period is pure data: captured on grant, no reset needed.
  always_ff @(posedge clk) begin
    if (load_period) period_q <= period_sel;
  end

endmodule
